ws2812_chain: RTL and testbench
===============================

WS2812_CHAIN -- requirements
Module: ws2812_chain

Interface
REQ-001 Parameter NUM_LEDS, default 8: number of pixels in the chain and depth of the pixel buffer, minimum 1.
REQ-002 Parameter T0H_CYC, default 20: high time of a '0' bit, in i_Clock cycles.
REQ-003 Parameter T1H_CYC, default 40: high time of a '1' bit, in i_Clock cycles.
REQ-004 Parameter BIT_CYC, default 63: total bit period, in cycles; the design SHALL require 0 < T0H_CYC < T1H_CYC < BIT_CYC.
REQ-005 Parameter RESET_CYC, default 15000: low latch gap after the frame, in cycles.
REQ-006 i_Clock  input  1  the single clock; all logic on its rising edge.
REQ-007 i_Reset  input  1  synchronous, active-high reset.
REQ-008 i_Wr_En  input  1  pixel buffer write strobe.
REQ-009 i_Wr_Addr  input  clog2(NUM_LEDS) (min 1)  pixel index; index 0 is transmitted first.
REQ-010 i_Wr_Data  input  24  pixel value ordered {G,R,B}, 8 bits each.
REQ-011 i_Start  input  1  frame start request, level-sampled.
REQ-012 o_Led  output  1  serial data line to the first LED.
REQ-013 o_Ready  output  1  high when in IDLE: start and writes are accepted.
REQ-014 o_Done  output  1  one-cycle pulse when the latch gap completes.

Function
REQ-015 The state machine SHALL have states IDLE, LOAD, HIGH, LOW and LATCH.
REQ-016 IDLE: o_Led=0, o_Ready=1; i_Start=1 SHALL move to LOAD, with the pixel counter at 0 and the bit counter at 23.
REQ-017 LOAD lasts one cycle: it reads pixel 0 into the shift register, then moves to HIGH.
REQ-018 o_Led SHALL rise on the second rising edge after the edge that samples i_Start.
REQ-019 HIGH: o_Led=1 for T1H_CYC cycles if the current bit is 1, T0H_CYC cycles if it is 0; then LOW.
REQ-020 LOW: o_Led=0 for the rest of BIT_CYC, so every bit is exactly BIT_CYC cycles long.
REQ-021 Bits SHALL be sent MSB first (G7 first, B0 last).
REQ-022 After bit 0 of a pixel that is not the last, the next bit SHALL start with no gap cycles.
REQ-023 To allow REQ-022, the next pixel SHALL be prefetched from the buffer during the current pixel.
REQ-024 After bit 0 of pixel NUM_LEDS-1 the state SHALL go to LATCH, holding o_Led=0 for RESET_CYC cycles.
REQ-025 At the end of LATCH the state SHALL go to IDLE with o_Done=1 for exactly one cycle.
REQ-026 A frame SHALL last NUM_LEDS*24*BIT_CYC + RESET_CYC cycles from the first o_Led rise to o_Done.
REQ-027 Writes SHALL commit only when o_Ready=1 and i_Wr_Addr < NUM_LEDS; otherwise they SHALL be dropped silently.
REQ-028 If i_Wr_En and i_Start are both high in IDLE, the write SHALL commit and that frame SHALL transmit the new value.
REQ-029 i_Start while not in IDLE SHALL be ignored, not queued.
REQ-030 i_Start held high SHALL start a new frame on the cycle after o_Done.
REQ-031 All outputs SHALL be registered; counters SHALL be sized with clog2 of their maximum count and SHALL never wrap.

Reset
REQ-032 i_Reset=1 SHALL force IDLE, o_Led=0, o_Ready=1, o_Done=0, and clear all counters on the next edge, including mid-frame.
REQ-033 Reset SHALL NOT clear buffer contents; the buffer power-up value is all zeros.
REQ-034 Reset SHALL take priority over i_Start and i_Wr_En in the same cycle.

Configuration
REQ-035 With WS2812_BRIGHTNESS_EN defined, the design SHALL add input i_Brightness [7:0].
REQ-036 With WS2812_BRIGHTNESS_EN defined, i_Brightness is latched in LOAD and each channel is sent as (c*(B+1))>>8, truncated.
REQ-037 Without WS2812_BRIGHTNESS_EN, the port SHALL be absent and pixel data sent unmodified.

Verification
REQ-038 NUM_LEDS=2; write 0:24'hFF0000 and 1:24'h000001; start -> bits 1 are 40 high / 23 low, bits 0 are 20 high / 43 low; the last bit is a '1'; o_Done 3024+15000 cycles after the first rise.
REQ-039 Start pulse in IDLE -> o_Led high at edge 2; o_Ready low the cycle after the sampling edge.
REQ-040 Write addr 1 with 24'hAAAAAA mid-frame, and write addr 5 (NUM_LEDS=2) in IDLE -> both dropped; the next frame sends the old pixel 1.
REQ-041 Assert i_Reset during pixel 1 bit 10 -> o_Led=0, o_Ready=1 next edge; a following start sends the buffer intact.
REQ-042 Hold i_Start high -> frames back-to-back, o_Done once per frame, a new LOAD on the cycle after each o_Done.
REQ-043 WS2812_BRIGHTNESS_EN, i_Brightness=8'h7F, pixel 24'hFF8001 -> transmitted 24'h7F4000.

Source files
------------

// File: rtl/ws2812_chain.sv
// ws2812_chain: serial driver for a chain of WS2812 RGB LEDs.
//
// The pixel buffer holds NUM_LEDS 24-bit {G,R,B} words. i_Start sends every
// pixel as 24 NRZ bits, pixel 0 first and MSB first. Each bit has a high
// phase of T1H_CYC ('1') or T0H_CYC ('0') cycles and lasts BIT_CYC cycles in
// total. After the frame the line is held low for RESET_CYC cycles so the LEDs
// latch the data, and then o_Done pulses for one cycle.
//
// Optional feature macro: WS2812_BRIGHTNESS_EN
//   Adds i_Brightness[7:0]. The value is latched when a frame starts, and each
//   channel is sent as (c*(B+1))>>8.
//
// Ports
//   i_Clock       single clock, rising edge
//   i_Reset       synchronous active-high reset (pixel buffer is kept)
//   i_Wr_En       pixel write strobe, only taken while o_Ready=1
//   i_Wr_Addr     pixel index, 0 is transmitted first
//   i_Wr_Data     pixel value {G,R,B}
//   i_Start       frame request, level sensitive, only taken while o_Ready=1
//   i_Brightness  global brightness (only with WS2812_BRIGHTNESS_EN)
//   o_Led         serial data line to the first LED
//   o_Ready       high while idle
//   o_Done        one-cycle pulse when the latch gap ends
//
// States
//   IDLE  | line low, buffer writable, waiting for i_Start
//   LOAD  | one cycle: pixel 0 -> shift register
//   HIGH  | high phase of the current bit
//   LOW   | low remainder of the current bit
//   LATCH | low latch gap after the last bit

module ws2812_chain #(
  parameter int NUM_LEDS  = 8,
  parameter int T0H_CYC   = 20,
  parameter int T1H_CYC   = 40,
  parameter int BIT_CYC   = 63,
  parameter int RESET_CYC = 15000,
  localparam int AW = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
  input  logic          i_Clock,
  input  logic          i_Reset,
  input  logic          i_Wr_En,
  input  logic [AW-1:0] i_Wr_Addr,
  input  logic [23:0]   i_Wr_Data,
  input  logic          i_Start,
`ifdef WS2812_BRIGHTNESS_EN
  input  logic [7:0]    i_Brightness,
`endif
  output logic          o_Led,
  output logic          o_Ready,
  output logic          o_Done
);

  // A single down-counter times both the bit phases and the latch gap. It is
  // sized for the larger of the two reload values.
  localparam int TMAX = (RESET_CYC + 1 > BIT_CYC) ? RESET_CYC + 1 : BIT_CYC;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  // Each reload value is one less than the phase length, because the
  // counter counts down to zero inclusive.
  localparam logic [TW-1:0] T0H_LD   = TW'(T0H_CYC - 1);
  localparam logic [TW-1:0] T1H_LD   = TW'(T1H_CYC - 1);
  localparam logic [TW-1:0] L0_LD    = TW'(BIT_CYC - T0H_CYC - 1);
  localparam logic [TW-1:0] L1_LD    = TW'(BIT_CYC - T1H_CYC - 1);
  // The latch state lasts one cycle longer than the gap. o_Led lags the
  // state by one cycle, so the line is low for exactly RESET_CYC cycles after
  // the low phase of the last bit. o_Done therefore lands exactly
  // NUM_LEDS*24*BIT_CYC + RESET_CYC cycles after the first rise.
  localparam logic [TW-1:0] LATCH_LD = TW'(RESET_CYC);

  localparam logic [AW-1:0] LAST_PIX = AW'(NUM_LEDS - 1);
  localparam logic [AW:0]   NUM_W    = (AW + 1)'(NUM_LEDS);
  localparam logic [4:0]    MSB_BIT  = 5'd23;

  typedef enum logic [2:0] {IDLE, LOAD, HIGH, LOW, LATCH} state_t;

  state_t        state;
  logic [AW-1:0] pix_cnt;
  logic [4:0]    bit_cnt;
  logic [TW-1:0] timer;
  logic [23:0]   shift;
  logic [23:0]   prefetch;
  logic [AW-1:0] next_idx;
  logic [23:0]   load_pix;
  logic [23:0]   next_pix;

  logic [23:0] pix_mem [NUM_LEDS] = '{default: 24'h0};

  always_ff @(posedge i_Clock) begin
    if (!i_Reset && i_Wr_En && o_Ready && ({1'b0, i_Wr_Addr} < NUM_W)) begin
      pix_mem[i_Wr_Addr] <= i_Wr_Data;
    end
  end

  // The next pixel is read while the current one is being sent. The read is
  // clamped on the last pixel so the index never leaves the buffer.
  always_comb begin
    next_idx = pix_cnt;
    if (pix_cnt != LAST_PIX) begin
      next_idx = pix_cnt + AW'(1);
    end
  end

`ifdef WS2812_BRIGHTNESS_EN
  logic [7:0] bright_q;

  function automatic logic [7:0] dim(input logic [7:0] c, input logic [7:0] b);
    logic [16:0] prod;
    prod = {9'd0, c} * {8'd0, ({1'b0, b} + 9'd1)};
    return prod[15:8];
  endfunction

  function automatic logic [23:0] scale(input logic [23:0] px, input logic [7:0] b);
    return {dim(px[23:16], b), dim(px[15:8], b), dim(px[7:0], b)};
  endfunction

  // Pixel 0 is scaled in the same cycle that the brightness is latched, so
  // it takes the live input. Every later pixel uses the latched copy.
  assign load_pix = scale(pix_mem[0], i_Brightness);
  assign next_pix = scale(pix_mem[next_idx], bright_q);

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      bright_q <= 8'h00;
    end else if (state == LOAD) begin
      bright_q <= i_Brightness;
    end
  end
`else
  assign load_pix = pix_mem[0];
  assign next_pix = pix_mem[next_idx];
`endif

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state    <= IDLE;
      pix_cnt  <= '0;
      bit_cnt  <= '0;
      timer    <= '0;
      shift    <= '0;
      prefetch <= '0;
      o_Led    <= 1'b0;
      o_Ready  <= 1'b1;
      o_Done   <= 1'b0;
    end else begin
      o_Led  <= (state == HIGH);
      o_Done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (i_Start) begin
            state   <= LOAD;
            pix_cnt <= '0;
            bit_cnt <= MSB_BIT;
            o_Ready <= 1'b0;
          end
        end
        LOAD: begin
          shift <= load_pix;
          timer <= load_pix[23] ? T1H_LD : T0H_LD;
          state <= HIGH;
        end
        HIGH: begin
          prefetch <= next_pix;
          if (timer == '0) begin
            timer <= shift[23] ? L1_LD : L0_LD;
            state <= LOW;
          end else begin
            timer <= timer - TW'(1);
          end
        end
        LOW: begin
          if (timer != '0) begin
            timer <= timer - TW'(1);
          end else if (bit_cnt != 5'd0) begin
            bit_cnt <= bit_cnt - 5'd1;
            shift   <= {shift[22:0], 1'b0};
            timer   <= shift[22] ? T1H_LD : T0H_LD;
            state   <= HIGH;
          end else if (pix_cnt == LAST_PIX) begin
            timer <= LATCH_LD;
            state <= LATCH;
          end else begin
            pix_cnt <= pix_cnt + AW'(1);
            bit_cnt <= MSB_BIT;
            shift   <= prefetch;
            timer   <= prefetch[23] ? T1H_LD : T0H_LD;
            state   <= HIGH;
          end
        end
        LATCH: begin
          if (timer != '0) begin
            timer <= timer - TW'(1);
          end else begin
            state   <= IDLE;
            o_Ready <= 1'b1;
            o_Done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ws2812_chain.sv
// Testbench for ws2812_chain with NUM_LEDS=2 and the default timing.
// The stimulus process queues the pixels that each frame should carry. A
// monitor decodes o_Led into bits and pixels and compares them against that
// queue, together with the bit timing and the frame length.
module tb_ws2812_chain;

  localparam int NUM_LEDS  = 2;
  localparam int T0H_CYC   = 20;
  localparam int T1H_CYC   = 40;
  localparam int BIT_CYC   = 63;
  localparam int RESET_CYC = 15000;
  localparam int FRAME_CYC = 3024 + 15000;
  localparam int FRAME_TMO = FRAME_CYC + 200;

  logic        clk = 1'b0;
  logic        i_Reset = 1'b1;
  logic        i_Wr_En = 1'b0;
  logic [0:0]  i_Wr_Addr = 1'b0;
  logic [23:0] i_Wr_Data = 24'h0;
  logic        i_Start = 1'b0;
  logic        o_Led, o_Ready, o_Done;
`ifdef WS2812_BRIGHTNESS_EN
  logic [7:0]  i_Brightness = 8'hFF;
`endif

  ws2812_chain #(
    .NUM_LEDS(NUM_LEDS), .T0H_CYC(T0H_CYC), .T1H_CYC(T1H_CYC),
    .BIT_CYC(BIT_CYC), .RESET_CYC(RESET_CYC)
  ) dut (
    .i_Clock(clk),
    .i_Reset(i_Reset),
    .i_Wr_En(i_Wr_En),
    .i_Wr_Addr(i_Wr_Addr),
    .i_Wr_Data(i_Wr_Data),
    .i_Start(i_Start),
`ifdef WS2812_BRIGHTNESS_EN
    .i_Brightness(i_Brightness),
`endif
    .o_Led(o_Led),
    .o_Ready(o_Ready),
    .o_Done(o_Done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int done_cnt = 0;
  logic [23:0] exp_q[$];

  always @(posedge clk) cyc++;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  // Monitor
  logic        prev_led = 1'b0;
  logic        in_frame = 1'b0;
  logic        done_seen = 1'b0;
  logic        start_at_done = 1'b0;
  int          high_len = 0, low_len = 0, bit_idx = 0, frame_bits = 0, first_rise = 0;
  logic [23:0] cur_exp = 24'h0;
  logic [23:0] acc = 24'h0;

  always @(negedge clk) begin
    if (i_Reset) begin
      in_frame = 1'b0; bit_idx = 0; frame_bits = 0;
      high_len = 0; low_len = 0; prev_led = 1'b0; done_seen = 1'b0;
      exp_q.delete();
    end else begin
      if (o_Led === 1'b1) begin
        if (!prev_led) begin
          if (!in_frame) begin
            in_frame = 1'b1; first_rise = cyc; frame_bits = 0;
          end else begin
            chk("bit_period", high_len + low_len, BIT_CYC);
          end
          if (bit_idx == 0) begin
            if (exp_q.size() == 0) begin
              n_cmp++; n_bad++;
              $display("FAIL unexpected_pixel: pixel started with empty queue (cycle %0d)", cyc);
              cur_exp = 24'h0;
            end else begin
              cur_exp = exp_q.pop_front();
            end
            acc = 24'h0;
          end
          high_len = 0;
        end
        high_len++;
      end else begin
        if (prev_led) begin
          chk("high_time", high_len, cur_exp[23 - bit_idx] ? T1H_CYC : T0H_CYC);
          acc = {acc[22:0], (high_len > (T0H_CYC + T1H_CYC) / 2)};
          bit_idx++; frame_bits++;
          if (bit_idx == 24) begin
            chk("pixel", acc, cur_exp);
            bit_idx = 0;
          end
          low_len = 0;
        end
        low_len++;
      end
      if (o_Done === 1'b1) begin
        chk("frame_len", cyc - first_rise, FRAME_CYC);
        chk("frame_bits", frame_bits, NUM_LEDS * 24);
        done_cnt++;
        in_frame = 1'b0;
        done_seen = 1'b1;
        start_at_done = i_Start;
      end else if (done_seen) begin
        if (start_at_done) chk("restart_load", o_Ready, 1'b0);
        done_seen = 1'b0;
      end
      prev_led = o_Led;
    end
  end

  // Stimulus
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic write_px(input logic [0:0] a, input logic [23:0] d);
    i_Wr_En = 1'b1; i_Wr_Addr = a; i_Wr_Data = d;
    step();
    i_Wr_En = 1'b0;
  endtask

  task automatic push_frame(input logic [23:0] p0, input logic [23:0] p1);
    exp_q.push_back(p0);
    exp_q.push_back(p1);
  endtask

  task automatic wait_done(input int lim);
    int k = 0;
    do begin @(negedge clk); k++; end while (o_Done !== 1'b1 && k < lim);
    chk("done_seen", o_Done, 1'b1);
  endtask

  task automatic wait_rise(input int lim);
    int k = 0;
    do begin @(negedge clk); k++; end while (o_Led !== 1'b1 && k < lim);
    chk("rise_seen", o_Led, 1'b1);
  endtask

  int exp_dones = 0;

  initial begin
    repeat (3) step();
    i_Reset = 1'b0;
    @(negedge clk);
    chk("rst_led", o_Led, 1'b0);
    chk("rst_ready", o_Ready, 1'b1);
    chk("rst_done", o_Done, 1'b0);

    // Frame 1: pixel 1 is written in the same cycle as the start request.
    step();
    write_px(1'b0, 24'hFF0000);
    push_frame(24'hFF0000, 24'h000001);
    i_Wr_En = 1'b1; i_Wr_Addr = 1'b1; i_Wr_Data = 24'h000001; i_Start = 1'b1;
    @(posedge clk); #1;
    i_Wr_En = 1'b0; i_Start = 1'b0;
    @(negedge clk);
    chk("ready_after_start", o_Ready, 1'b0);
    chk("led_edge0", o_Led, 1'b0);
    @(negedge clk);
    chk("led_edge1", o_Led, 1'b0);
    @(negedge clk);
    chk("led_edge2", o_Led, 1'b1);
    wait_done(FRAME_TMO);
    exp_dones++;

    // Frame 2: a write issued mid-frame must be dropped, and so must a start
    // request issued mid-frame.
    step();
    push_frame(24'hFF0000, 24'h000001);
    i_Start = 1'b1; step(); i_Start = 1'b0;
    repeat (100) step();
    chk("ready_midframe", o_Ready, 1'b0);
    write_px(1'b1, 24'hAAAAAA);
    i_Start = 1'b1; step(); i_Start = 1'b0;
    wait_done(FRAME_TMO);
    exp_dones++;

    // Frame 3: reset at pixel 1, bit 10. The write and start issued in the
    // same cycle as the reset must lose to it.
    step();
    push_frame(24'hFF0000, 24'h000001);
    i_Start = 1'b1; step(); i_Start = 1'b0;
    wait_rise(10);
    repeat ((24 + 13) * BIT_CYC + 5) @(posedge clk);
    #1;
    i_Reset = 1'b1; i_Start = 1'b1;
    i_Wr_En = 1'b1; i_Wr_Addr = 1'b0; i_Wr_Data = 24'h123456;
    step();
    i_Reset = 1'b0; i_Start = 1'b0; i_Wr_En = 1'b0;
    @(negedge clk);
    chk("midrst_led", o_Led, 1'b0);
    chk("midrst_ready", o_Ready, 1'b1);
    chk("midrst_done", o_Done, 1'b0);

    // Frames 4 and 5: start is held high, so the frames run back to back
    // and the buffer must be intact after the reset.
    step();
    push_frame(24'hFF0000, 24'h000001);
    push_frame(24'hFF0000, 24'h000001);
    i_Start = 1'b1;
    wait_done(FRAME_TMO);
    exp_dones++;
    wait_rise(10);
    repeat (100) step();
    i_Start = 1'b0;
    wait_done(FRAME_TMO);
    exp_dones++;

`ifdef WS2812_BRIGHTNESS_EN
    step();
    i_Brightness = 8'h7F;
    write_px(1'b0, 24'hFF8001);
    push_frame(24'h7F4000, 24'h000000);
    i_Start = 1'b1; step(); i_Start = 1'b0;
    wait_done(FRAME_TMO);
    exp_dones++;
`endif

    repeat (200) step();
    @(negedge clk);
    chk("final_led", o_Led, 1'b0);
    chk("final_ready", o_Ready, 1'b1);
    chk("done_count", done_cnt, exp_dones);
    chk("queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
